// File: rtl/decrypt_controller.sv
// Sequencing controller for the AES-128 inverse cipher. It expands the key
// when needed, then steps the datapath through the rounds with keys 10..0.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for decrypt; init/key_load issued on start
// S_EXPAND | writing generated round keys 1..10 into the key RAM
// S_ADDKEY | initial AddRoundKey with round key 10
// S_ROUND  | full inverse rounds using keys 9..1
// S_FINAL  | last round without InvMixColumns, key 0
// S_OUTPUT | strobe plaintext into the output register
// S_DONE   | result valid; held until decrypt is withdrawn
module decrypt_controller (
  input  logic       clock,
  input  logic       reset,
  input  logic       decrypt,
  input  logic       new_key,
  input  logic       abort,
  output logic       init,
  output logic       key_load,
  output logic       key_we,
  output logic [3:0] key_addr,
  output logic       round_en,
  output logic       add_key_only,
  output logic       skip_mix,
  output logic       en_Dout,
  output logic       done,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_EXPAND, S_ADDKEY, S_ROUND, S_FINAL, S_OUTPUT, S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] count_q, count_d;
  logic       key_loaded_q, key_loaded_d;

  // Next-state logic and combinational output decode from state/count/inputs.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    key_loaded_d = key_loaded_q;
    init         = 1'b0;
    key_load     = 1'b0;
    key_we       = 1'b0;
    key_addr     = 4'd0;
    round_en     = 1'b0;
    add_key_only = 1'b0;
    skip_mix     = 1'b0;
    en_Dout      = 1'b0;
    done         = 1'b0;
    busy         = (state_q != S_IDLE) && (state_q != S_DONE);

    case (state_q)
      S_IDLE: begin
        // An abort here is ignored but still suppresses the start.
        if (decrypt && !abort) begin
          init = 1'b1;
          if (new_key || !key_loaded_q) begin
            key_load = 1'b1;
            count_d  = 4'd1;
            state_d  = S_EXPAND;
          end else begin
            count_d  = 4'd10;
            state_d  = S_ADDKEY;
          end
        end
      end
      S_EXPAND: begin
        key_we   = 1'b1;
        key_addr = count_q;
        if (count_q == 4'd10) begin
          key_loaded_d = 1'b1;
          state_d      = S_ADDKEY;
        end else begin
          count_d = count_q + 4'd1;
        end
      end
      S_ADDKEY: begin
        round_en     = 1'b1;
        add_key_only = 1'b1;
        key_addr     = 4'd10;
        count_d      = 4'd9;
        state_d      = S_ROUND;
      end
      S_ROUND: begin
        round_en = 1'b1;
        key_addr = count_q;
        if (count_q == 4'd1) begin
          count_d = 4'd0;
          state_d = S_FINAL;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      S_FINAL: begin
        round_en = 1'b1;
        skip_mix = 1'b1;
        state_d  = S_OUTPUT;
      end
      S_OUTPUT: begin
        en_Dout = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (!decrypt) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        count_d = 4'd0;
      end
    endcase

    // Abort wins over every normal transition; a partial expansion is discarded.
    if (abort && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      count_d  = 4'd0;
      init     = 1'b0;
      key_load = 1'b0;
      key_we   = 1'b0;
      round_en = 1'b0;
      en_Dout  = 1'b0;
      if (state_q == S_EXPAND) key_loaded_d = 1'b0;
    end

    // Outputs read as zero for as long as reset is held, even with decrypt high.
    if (!reset) begin
      init         = 1'b0;
      key_load     = 1'b0;
      key_we       = 1'b0;
      key_addr     = 4'd0;
      round_en     = 1'b0;
      add_key_only = 1'b0;
      skip_mix     = 1'b0;
      en_Dout      = 1'b0;
      done         = 1'b0;
      busy         = 1'b0;
    end
  end

  // State, round counter and key-valid flag registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      count_q      <= 4'd0;
      key_loaded_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      key_loaded_q <= key_loaded_d;
    end
  end

endmodule

// File: tb/tb_decrypt_controller.sv
// Cycle-accurate bench for decrypt_controller: expected output vectors come
// from the cycle-numbering tables, are queued as stimulus is applied and are
// popped against the captured DUT outputs.
module tb_decrypt_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       decrypt = 1'b0;
  logic       new_key = 1'b0;
  logic       abort = 1'b0;
  logic       init, key_load, key_we, round_en, add_key_only, skip_mix;
  logic       en_Dout, done, busy;
  logic [3:0] key_addr;

  typedef struct packed {
    logic       init;
    logic       key_load;
    logic       key_we;
    logic [3:0] key_addr;
    logic       round_en;
    logic       add_key_only;
    logic       skip_mix;
    logic       en_Dout;
    logic       done;
    logic       busy;
  } vec_t;

  vec_t exp_q[$];
  vec_t act_q[$];
  int   errors = 0;
  int   checks = 0;

  localparam int NONE = 100000;

  decrypt_controller dut (
    .clock(clock), .reset(reset), .decrypt(decrypt), .new_key(new_key),
    .abort(abort), .init(init), .key_load(key_load), .key_we(key_we),
    .key_addr(key_addr), .round_en(round_en), .add_key_only(add_key_only),
    .skip_mix(skip_mix), .en_Dout(en_Dout), .done(done), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic vec_t cur();
    vec_t v;
    v = '{init, key_load, key_we, key_addr, round_en, add_key_only,
          skip_mix, en_Dout, done, busy};
    return v;
  endfunction

  // Expected outputs for cycle c of an operation (cycle 0 = start in IDLE);
  // drop is the first cycle with decrypt low.
  function automatic vec_t base_vec(bit expand, int c, int drop);
    vec_t v;
    int   e;
    v = '0;
    e = expand ? 10 : 0;
    if (c == 0) begin
      v.init = 1'b1; v.key_load = expand;
    end else if (c <= e) begin
      v.key_we = 1'b1; v.key_addr = 4'(c); v.busy = 1'b1;
    end else if (c == e + 1) begin
      v.round_en = 1'b1; v.add_key_only = 1'b1; v.key_addr = 4'd10; v.busy = 1'b1;
    end else if (c <= e + 10) begin
      v.round_en = 1'b1; v.key_addr = 4'(e + 11 - c); v.busy = 1'b1;
    end else if (c == e + 11) begin
      v.round_en = 1'b1; v.skip_mix = 1'b1; v.busy = 1'b1;
    end else if (c == e + 12) begin
      v.en_Dout = 1'b1; v.busy = 1'b1;
    end else if (c <= drop) begin
      v.done = 1'b1;
    end
    return v;
  endfunction

  // Drives one operation cycle by cycle, queuing expected and observed vectors.
  task automatic run_op(input bit newk, input bit expand, input int abort_at,
                        input int drop, input int n_cycles);
    vec_t ev;
    for (int c = 0; c < n_cycles; c++) begin
      @(negedge clock);
      decrypt = (c < drop) && (c < abort_at);
      new_key = newk;
      abort   = (c == abort_at);
      ev = base_vec(expand, c, drop);
      if (c == abort_at) begin
        ev.init = 1'b0; ev.key_load = 1'b0; ev.key_we = 1'b0;
        ev.round_en = 1'b0; ev.en_Dout = 1'b0;
      end
      if (c > abort_at) ev = '0;
      exp_q.push_back(ev);
      #1;
      act_q.push_back(cur());
    end
  endtask

  task automatic test_reset();
    vec_t a;
    reset = 1'b0; decrypt = 1'b0; new_key = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    a = cur();
    checks++;
    if (a !== vec_t'('0)) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", a, vec_t'('0));
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_first_decrypt();
    vec_t e, a;
    int   i = 0;
    run_op(1'b0, 1'b1, NONE, 25, 27);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL first_decrypt cycle %0d: got %h expected %h", i, a, e);
      end
      i++;
    end
  endtask

  task automatic test_key_reuse();
    vec_t e, a;
    int   i = 0;
    run_op(1'b0, 1'b0, NONE, 14, 16);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL key_reuse cycle %0d: got %h expected %h", i, a, e);
      end
      i++;
    end
  endtask

  task automatic test_rekey();
    vec_t e, a;
    int   i = 0;
    run_op(1'b1, 1'b1, NONE, 24, 26);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL rekey cycle %0d: got %h expected %h", i, a, e);
      end
      i++;
    end
  endtask

  task automatic test_abort_expand();
    vec_t e, a;
    int   i = 0;
    run_op(1'b1, 1'b1, 5, NONE, 8);
    // key_loaded must have been cleared: new_key=0 still expands.
    run_op(1'b0, 1'b1, NONE, 24, 26);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL abort_expand step %0d: got %h expected %h", i, a, e);
      end
      i++;
    end
  endtask

  task automatic test_abort_round();
    vec_t e, a;
    int   i = 0;
    run_op(1'b0, 1'b0, 5, NONE, 16);
    // key_loaded survives a ROUND abort: next run skips expansion.
    run_op(1'b0, 1'b0, NONE, 14, 16);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL abort_round step %0d: got %h expected %h", i, a, e);
      end
      i++;
    end
  endtask

  task automatic test_done_hold();
    vec_t e, a;
    int   i = 0;
    run_op(1'b0, 1'b0, NONE, 18, 20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL done_hold cycle %0d: got %h expected %h", i, a, e);
      end
      i++;
    end
  endtask

  task automatic test_abort_idle_done();
    vec_t e, a;
    int   i = 0;
    @(negedge clock);
    decrypt = 1'b1; new_key = 1'b0; abort = 1'b1;
    exp_q.push_back('0);
    #1;
    act_q.push_back(cur());
    run_op(1'b0, 1'b0, 14, NONE, 18);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL abort_idle_done step %0d: got %h expected %h", i, a, e);
      end
      i++;
    end
  endtask

  task automatic test_back_to_back();
    vec_t e, a;
    int   i = 0;
    run_op(1'b0, 1'b0, NONE, 14, 15);
    run_op(1'b0, 1'b0, NONE, 14, 16);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL back_to_back step %0d: got %h expected %h", i, a, e);
      end
      i++;
    end
  endtask

  task automatic test_async_reset();
    vec_t e, a;
    int   i = 0;
    run_op(1'b0, 1'b0, NONE, NONE, 16);
    #2;
    reset = 1'b0;
    #1;
    exp_q.push_back('0);
    act_q.push_back(cur());
    @(posedge clock);
    #1;
    exp_q.push_back('0);
    act_q.push_back(cur());
    @(negedge clock);
    reset = 1'b1; decrypt = 1'b0;
    #1;
    exp_q.push_back('0);
    act_q.push_back(cur());
    // Reset cleared key_loaded, so new_key=0 must expand again.
    run_op(1'b0, 1'b1, NONE, 24, 26);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL async_reset step %0d: got %h expected %h", i, a, e);
      end
      i++;
    end
  endtask

  initial begin
    test_reset();
    test_first_decrypt();
    test_key_reuse();
    test_rekey();
    test_abort_expand();
    test_abort_round();
    test_done_hold();
    test_abort_idle_done();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
